// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised input, mid-bit sampling,
// one-cycle valid / frame_err pulses and a sticky overrun flag.
module uart_rx #(
    parameter int BAUD = 9600,
    parameter int F    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CPB = F / BAUD;
    localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx;
    logic [7:0]      r_shreg;
    logic [7:0]      w_shreg;
    logic [7:0]      r_data;
    logic [7:0]      w_data;
    logic            r_valid;
    logic            w_valid;
    logic            r_ferr;
    logic            w_ferr;
    logic            r_pend;
    logic            w_pend;
    logic            r_ovr;
    logic            w_ovr;

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shreg <= w_shreg;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
            r_pend  <= w_pend;
            r_ovr   <= w_ovr;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_shreg = r_shreg;
        w_data  = r_data;
        w_valid = 1'b0;
        w_ferr  = 1'b0;
        w_pend  = r_pend;
        w_ovr   = r_ovr;
        if (ack) begin
            w_pend = 1'b0;
            w_ovr  = 1'b0;
        end
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state = S_START;
                    w_cnt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt = '0;
                    if (w_rx_s) begin
                        w_state = S_IDLE;
                    end else begin
                        w_state = S_DATA;
                        w_idx   = '0;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt          = '0;
                    w_shreg[r_idx] = w_rx_s;
                    if (r_idx == 3'd7) begin
                        w_state = S_STOP;
                    end else begin
                        w_idx = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt = '0;
                    if (w_rx_s) begin
                        // A simultaneous ack frees the slot, so no overrun
                        w_data  = r_shreg;
                        w_valid = 1'b1;
                        w_ovr   = ack ? 1'b0 : (r_ovr | r_pend);
                        w_pend  = 1'b1;
                        w_state = S_IDLE;
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = S_WAIT;
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (w_rx_s) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign busy      = (r_state != S_IDLE);

endmodule
